// File: rtl/intra16_mode_ctrl_if.sv
// Scheduler/datapath-facing bundle of the 16x16 intra mode controller.
// The master drives requests and pixel data; the slave is the controller.
interface intra16_mode_ctrl_if #(
  parameter int PW = 8,
  parameter int N  = 16
);
  localparam int RW = $clog2(N);
  localparam int AW = PW + 2 * RW;

  logic            start;
  logic            abort;
  logic            top_avail;
  logic            left_avail;
  logic [N*PW-1:0] top_pix;
  logic [N*PW-1:0] left_pix;
  logic            org_req;
  logic [RW-1:0]   org_row;
  logic            org_valid;
  logic [N*PW-1:0] org_data;
  logic            pred_en;
  logic [PW-1:0]   dc_value;
  logic            busy;
  logic            done;
  logic [1:0]      best_mode;
  logic [AW-1:0]   best_sad;

  modport master (
    output start, abort, top_avail, left_avail, top_pix, left_pix,
           org_valid, org_data,
    input  org_req, org_row, pred_en, dc_value, busy, done, best_mode, best_sad
  );

  modport slave (
    input  start, abort, top_avail, left_avail, top_pix, left_pix,
           org_valid, org_data,
    output org_req, org_row, pred_en, dc_value, busy, done, best_mode, best_sad
  );
endinterface

// File: rtl/intra16_mode_ctrl.sv
// 16x16 luma intra sequencer: latches neighbours, derives DC, fetches the
// original rows, accumulates V/H/DC SADs and reports the cheapest mode.
module intra16_mode_ctrl #(
  parameter int PW = 8,
  parameter int N  = 16
) (
  input logic               clk,
  input logic               reset,
  intra16_mode_ctrl_if.slave bus
);
  localparam int RW = $clog2(N);
  localparam int SW = PW + RW;
  localparam int AW = SW + RW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRED  = 3'd2,
    FETCH = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state;
  logic [N*PW-1:0] top_q;
  logic [N*PW-1:0] left_q;
  logic            top_av_q;
  logic            left_av_q;
  logic [AW-1:0]   acc_v;
  logic [AW-1:0]   acc_h;
  logic [AW-1:0]   acc_dc;

  logic            org_req_q;
  logic [RW-1:0]   row_q;
  logic            pred_en_q;
  logic [PW-1:0]   dc_q;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      best_mode_q;
  logic [AW-1:0]   best_sad_q;

  logic [SW-1:0]   sum_t;
  logic [SW-1:0]   sum_l;
  logic [SW:0]     dc_wide;
  logic [PW-1:0]   dc_next;
  logic [PW-1:0]   left_r;
  logic [SW-1:0]   row_v;
  logic [SW-1:0]   row_h;
  logic [SW-1:0]   row_dc;
  logic [1:0]      cmp_mode;
  logic [AW-1:0]   cmp_sad;

  function automatic logic [PW-1:0] absdiff(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum_t = sum_t + SW'(top_q[k*PW +: PW]);
      sum_l = sum_l + SW'(left_q[k*PW +: PW]);
    end
    case ({top_av_q, left_av_q})
      2'b11:   dc_wide = ({1'b0, sum_t} + {1'b0, sum_l} + (SW+1)'(N)) >> (RW + 1);
      2'b10:   dc_wide = ({1'b0, sum_t} + (SW+1)'(N / 2)) >> RW;
      2'b01:   dc_wide = ({1'b0, sum_l} + (SW+1)'(N / 2)) >> RW;
      default: dc_wide = (SW+1)'(1) << (PW - 1);
    endcase
    dc_next = dc_wide[PW-1:0];
  end

  always_comb begin
    left_r = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (RW'(k) == row_q) left_r = left_q[k*PW +: PW];
    end
    row_v  = '0;
    row_h  = '0;
    row_dc = '0;
    for (int unsigned k = 0; k < N; k++) begin
      row_v  = row_v  + SW'(absdiff(bus.org_data[k*PW +: PW], top_q[k*PW +: PW]));
      row_h  = row_h  + SW'(absdiff(bus.org_data[k*PW +: PW], left_r));
      row_dc = row_dc + SW'(absdiff(bus.org_data[k*PW +: PW], dc_q));
    end
  end

  // Candidates are visited lowest priority first so that <= lets V win ties over H, and H over DC.
  always_comb begin
    cmp_mode = 2'd2;
    cmp_sad  = acc_dc;
    if (left_av_q && (acc_h <= cmp_sad)) begin
      cmp_mode = 2'd1;
      cmp_sad  = acc_h;
    end
    if (top_av_q && (acc_v <= cmp_sad)) begin
      cmp_mode = 2'd0;
      cmp_sad  = acc_v;
    end
  end

  // Outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      top_q       <= '0;
      left_q      <= '0;
      top_av_q    <= 1'b0;
      left_av_q   <= 1'b0;
      acc_v       <= '0;
      acc_h       <= '0;
      acc_dc      <= '0;
      org_req_q   <= 1'b0;
      row_q       <= '0;
      pred_en_q   <= 1'b0;
      dc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_mode_q <= '0;
      best_sad_q  <= '0;
    end else begin
      pred_en_q <= 1'b0;
      done_q    <= 1'b0;
      if (bus.abort && (state != IDLE)) begin
        state     <= IDLE;
        busy_q    <= 1'b0;
        org_req_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              top_q     <= bus.top_pix;
              left_q    <= bus.left_pix;
              top_av_q  <= bus.top_avail;
              left_av_q <= bus.left_avail;
              busy_q    <= 1'b1;
              state     <= LOAD;
            end
          end
          LOAD: begin
            dc_q      <= dc_next;
            acc_v     <= '0;
            acc_h     <= '0;
            acc_dc    <= '0;
            pred_en_q <= 1'b1;
            state     <= PRED;
          end
          PRED: begin
            row_q     <= '0;
            org_req_q <= 1'b1;
            state     <= FETCH;
          end
          FETCH: begin
            if (bus.org_valid) begin
              acc_v  <= acc_v  + AW'(row_v);
              acc_h  <= acc_h  + AW'(row_h);
              acc_dc <= acc_dc + AW'(row_dc);
              row_q  <= row_q + 1'b1;
              if (row_q == RW'(N - 1)) begin
                org_req_q <= 1'b0;
                state     <= CMP;
              end
            end
          end
          CMP: begin
            best_mode_q <= cmp_mode;
            best_sad_q  <= cmp_sad;
            done_q      <= 1'b1;
            state       <= DONE;
          end
          DONE: begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            busy_q    <= 1'b0;
            org_req_q <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.org_req   = org_req_q;
  assign bus.org_row   = row_q;
  assign bus.pred_en   = pred_en_q;
  assign bus.dc_value  = dc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.best_mode = best_mode_q;
  assign bus.best_sad  = best_sad_q;
endmodule

// File: tb/tb_intra16_mode_ctrl.sv
// Directed bench for intra16_mode_ctrl: hand-computed mode/SAD/DC results,
// latency, stalled fetch, abort, ignored starts and asynchronous reset.
module tb_intra16_mode_ctrl;
  localparam int PW = 8;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intra16_mode_ctrl_if #(.PW(PW), .N(N)) bus ();
  intra16_mode_ctrl #(.PW(PW), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [PW-1:0]   row_val [N];
  logic [N*PW-1:0] stripes;
  int done_cyc, pred_cyc, beats, order_err, seen;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*PW-1:0] fill(input logic [PW-1:0] v);
    return {N{v}};
  endfunction

  task automatic set_nb(input logic ta, input logic la,
                        input logic [N*PW-1:0] t, input logic [N*PW-1:0] l);
    bus.top_avail  = ta;
    bus.left_avail = la;
    bus.top_pix    = t;
    bus.left_pix   = l;
  endtask

  task automatic set_rows_const(input logic [PW-1:0] v);
    for (int r = 0; r < N; r++) row_val[r] = v;
  endtask

  // One macroblock: start at edge 0, serve rows until done, an abort or the cycle budget.
  task automatic run_mb(input bit stall, input int abort_row, input int start_at, input bit scramble,
                        output int dcyc, output int pcyc, output int nb, output int oerr);
    int cyc;
    dcyc = -1; pcyc = -1; nb = 0; oerr = 0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    if (scramble) set_nb(1'b0, 1'b0, fill(8'd255), '0);
    cyc = 1;
    for (int i = 0; i < 200; i++) begin
      if (bus.pred_en) pcyc = cyc;
      if (bus.done) begin
        dcyc = cyc;
        break;
      end
      bus.start     = (cyc == start_at);
      bus.org_valid = stall ? ((cyc % 3) == 0) : 1'b1;
      bus.org_data  = fill(row_val[bus.org_row]);
      bus.abort     = bus.org_req && (int'(bus.org_row) == abort_row);
      if (bus.org_req && bus.org_valid) begin
        if (int'(bus.org_row) != nb) oerr++;
        nb++;
      end
      tick;
      cyc++;
      if (bus.abort) break;
    end
    bus.start     = 1'b0;
    bus.org_valid = 1'b0;
    bus.abort     = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.org_valid = 1'b0; bus.org_data = '0;
    set_nb(1'b0, 1'b0, '0, '0);
    for (int r = 0; r < N; r++) stripes[r*PW +: PW] = PW'(10 * r);
    reset = 1'b1;
    #1;
    chk("reset_outputs", {bus.busy, bus.done, bus.pred_en, bus.org_req, bus.org_row,
                          bus.best_mode, bus.dc_value, bus.best_sad}, 32'd0);
    tick; tick;
    #2 reset = 1'b0;
    tick;

    // Flat block: dc = (1600+800+16)>>5 = 75, V exact.
    set_nb(1'b1, 1'b1, fill(8'd100), fill(8'd50));
    set_rows_const(8'd100);
    run_mb(1'b0, -1, -1, 1'b0, done_cyc, pred_cyc, beats, order_err);
    chk("t1_done_cyc", done_cyc, 20);
    chk("t1_mode", bus.best_mode, 0);
    chk("t1_sad", bus.best_sad, 0);
    chk("t1_dc", bus.dc_value, 75);
    tick;

    // Horizontal stripes: dc = (0+1200+16)>>5 = 38, H exact.
    set_nb(1'b1, 1'b1, '0, stripes);
    for (int r = 0; r < N; r++) row_val[r] = PW'(10 * r);
    run_mb(1'b0, -1, -1, 1'b0, done_cyc, pred_cyc, beats, order_err);
    chk("t2_pred_cyc", pred_cyc, 2);
    chk("t2_done_cyc", done_cyc, 20);
    chk("t2_beats", beats, 16);
    chk("t2_mode", bus.best_mode, 1);
    chk("t2_sad", bus.best_sad, 0);
    chk("t2_dc", bus.dc_value, 38);
    tick;

    // No neighbours: DC 128 is the only candidate.
    set_nb(1'b0, 1'b0, '0, '0);
    set_rows_const(8'd128);
    run_mb(1'b0, -1, -1, 1'b0, done_cyc, pred_cyc, beats, order_err);
    chk("t3a_mode", bus.best_mode, 2);
    chk("t3a_dc", bus.dc_value, 128);
    chk("t3a_sad", bus.best_sad, 0);
    tick;

    // Top only at 128: V and DC both 0, V wins the tie.
    set_nb(1'b1, 1'b0, fill(8'd128), '0);
    run_mb(1'b0, -1, -1, 1'b0, done_cyc, pred_cyc, beats, order_err);
    chk("t3b_mode", bus.best_mode, 0);
    chk("t3b_sad", bus.best_sad, 0);
    chk("t3b_dc", bus.dc_value, 128);
    tick;

    // Stalled fetch: valid on cycles 3,6,..,48 -> CMP 49, done 50.
    set_nb(1'b1, 1'b1, '0, stripes);
    for (int r = 0; r < N; r++) row_val[r] = PW'(10 * r);
    run_mb(1'b1, -1, -1, 1'b0, done_cyc, pred_cyc, beats, order_err);
    chk("t4_done_cyc", done_cyc, 50);
    chk("t4_beats", beats, 16);
    chk("t4_order_err", order_err, 0);
    chk("t4_mode", bus.best_mode, 1);
    chk("t4_sad", bus.best_sad, 0);
    tick;

    // Start mid-FETCH and neighbour changes after start are both ignored.
    set_nb(1'b1, 1'b1, '0, stripes);
    run_mb(1'b0, -1, 8, 1'b1, done_cyc, pred_cyc, beats, order_err);
    chk("t6b_done_cyc", done_cyc, 20);
    chk("t6b_mode", bus.best_mode, 1);
    chk("t6b_sad", bus.best_sad, 0);
    chk("t6b_dc", bus.dc_value, 38);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("t6b_start_in_done_busy", bus.busy, 0);
    tick;
    chk("t6b_still_idle", bus.busy, 0);

    // Max SAD: 16*16*255 = 65280 for V and DC (dc=0), V wins.
    set_nb(1'b1, 1'b0, '0, '0);
    set_rows_const(8'd255);
    run_mb(1'b0, -1, -1, 1'b0, done_cyc, pred_cyc, beats, order_err);
    chk("t5_mode", bus.best_mode, 0);
    chk("t5_sad", bus.best_sad, 65280);
    chk("t5_dc", bus.dc_value, 0);
    tick;

    // Abort during row 7: idle next cycle, no done, previous result held.
    set_nb(1'b1, 1'b1, fill(8'd100), fill(8'd50));
    set_rows_const(8'd100);
    run_mb(1'b0, 7, -1, 1'b0, done_cyc, pred_cyc, beats, order_err);
    chk("t6a_busy_after_abort", bus.busy, 0);
    chk("t6a_org_req_after_abort", bus.org_req, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) seen++;
      tick;
    end
    chk("t6a_no_done", seen, 0);
    chk("t6a_sad_held", bus.best_sad, 65280);

    // Asynchronous reset in the middle of FETCH.
    bus.start = 1'b1;
    tick;
    bus.start     = 1'b0;
    bus.org_valid = 1'b1;
    bus.org_data  = fill(8'd100);
    repeat (6) tick;
    chk("t6c_in_fetch", {bus.org_req, bus.busy}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("t6c_reset_outputs", {bus.busy, bus.done, bus.pred_en, bus.org_req, bus.org_row,
                              bus.best_mode, bus.dc_value}, 32'd0);
    chk("t6c_reset_sad", bus.best_sad, 0);
    #1 reset = 1'b0;
    bus.org_valid = 1'b0;
    tick;
    chk("t6c_idle_after_reset", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
